// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl
//   Single-port data memory with per-byte write masking, one-cycle registered
//   reads, write-first forwarding on read-during-write, out-of-range address
//   detection and a clear sequencer that zeroes the array after reset or when
//   requested.
//
// Ports
//   clock         single clock, all state updates on posedge
//   reset         asynchronous, active-high
//   readEnable    read request
//   writeEnable   write request
//   byteEnable    per-byte write mask, bit i covers dataIn[8i+7:8i]
//   address       word address
//   dataIn        write data
//   clearRequest  start a clear sweep (ignored while already clearing)
//   dataOut       registered read data, holds when no read completes
//   readValid     one-cycle pulse marking a read result on dataOut
//   ready         high when requests are accepted
//   addressError  one-cycle pulse for an out-of-range request

// Byte-lane merge: picks the incoming byte where the lane is enabled.
module data_ram_ctrl_lane (
    input  logic       enable,
    input  logic [7:0] old_byte,
    input  logic [7:0] new_byte,
    output logic [7:0] merged_byte
);
    assign merged_byte = enable ? new_byte : old_byte;
endmodule

module data_ram_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    readEnable,
    input  logic                    writeEnable,
    input  logic [DATA_WIDTH/8-1:0] byteEnable,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   dataIn,
    input  logic                    clearRequest,
    output logic [DATA_WIDTH-1:0]   dataOut,
    output logic                    readValid,
    output logic                    ready,
    output logic                    addressError
);
    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic { CLEAR, RUN } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t           state;
    logic [IDX_W-1:0] clear_pointer;

    logic                          in_range;
    logic [IDX_W-1:0]              mem_idx;
    logic                          accept;
    logic                          do_write;
    logic [NUM_LANES-1:0][7:0]     old_lanes;
    logic [NUM_LANES-1:0][7:0]     new_lanes;
    logic [NUM_LANES-1:0][7:0]     merged_lanes;

    // Extra top bit so the compare also works when DEPTH == 2^ADDR_WIDTH.
    assign in_range = ({1'b0, address} < (ADDR_WIDTH+1)'(DEPTH));
    // Out-of-range requests never touch the array; parking the index at 0
    // keeps the array read inside its bounds.
    assign mem_idx  = in_range ? address[IDX_W-1:0] : '0;

    // clearRequest wins over any read/write issued in the same cycle.
    assign accept   = (state == RUN) && !clearRequest;
    assign do_write = accept && writeEnable && in_range;

    assign old_lanes = mem[mem_idx];
    assign new_lanes = dataIn;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        data_ram_ctrl_lane u_lane (
            .enable      (byteEnable[i]),
            .old_byte    (old_lanes[i]),
            .new_byte    (new_lanes[i]),
            .merged_byte (merged_lanes[i])
        );
    end

    // Array port: the sweep owns it while clearing, otherwise the write path.
    always_ff @(posedge clock) begin
        if (state == CLEAR)
            mem[clear_pointer] <= '0;
        else if (do_write)
            mem[mem_idx] <= merged_lanes;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= CLEAR;
            clear_pointer <= '0;
            dataOut       <= '0;
            readValid     <= 1'b0;
            ready         <= 1'b0;
            addressError  <= 1'b0;
        end else begin
            readValid    <= 1'b0;
            addressError <= 1'b0;
            case (state)
                CLEAR: begin
                    clear_pointer <= clear_pointer + IDX_W'(1);
                    if (clear_pointer == IDX_W'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (clearRequest) begin
                        state         <= CLEAR;
                        clear_pointer <= '0;
                        ready         <= 1'b0;
                    end else begin
                        if (readEnable) begin
                            readValid <= 1'b1;
                            // Write-first: the merged word already reflects
                            // this cycle's write (merge is a no-op when idle).
                            if (!in_range)
                                dataOut <= '0;
                            else if (writeEnable)
                                dataOut <= merged_lanes;
                            else
                                dataOut <= old_lanes;
                        end
                        if ((readEnable || writeEnable) && !in_range)
                            addressError <= 1'b1;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule
